// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage feeding a downstream SIPO.
// A WIDTH-bit word is taken over a valid/ready handshake and shifted out
// MSB-first on SO, one bit per clk. frame_done pulses in the cycle where the
// downstream SIPO holds the complete word just sent.
//
// Handshake: a word transfers on a rising clk edge where din_valid and
// din_ready are both 1; din_valid raised while din_ready is 0 is ignored and
// din is not looked at.
//
// Optional build macro PISO_PARITY_EN: appends one even-parity bit (XOR of
// the word) after the LSB; the reload/idle decision moves to that cycle.
module piso_serializer #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             SO,
  output logic             so_valid,
  output logic             frame_done
);

  localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
    ,S_PARITY = 2'd2
`endif
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             load;
`ifdef PISO_PARITY_EN
  logic             parity;
`endif

  assign last_bit = (state == S_SHIFT) && (cnt == '0);
  assign load     = din_valid && din_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision: reload without a gap on the final cycle of a frame.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (din_valid) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == '0) begin
`ifdef PISO_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = din_valid ? S_SHIFT : S_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        state_next = din_valid ? S_SHIFT : S_IDLE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so SO is glitch-free per cycle.
  always_comb begin
    SO        = IDLE_LEVEL;
    so_valid  = 1'b0;
    din_ready = 1'b0;
    case (state)
      S_IDLE: begin
        din_ready = 1'b1;
      end
      S_SHIFT: begin
        SO       = shreg[WIDTH-1];
        so_valid = 1'b1;
`ifdef PISO_PARITY_EN
        din_ready = 1'b0;
`else
        din_ready = (cnt == '0);
`endif
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        SO        = parity;
        so_valid  = 1'b1;
        din_ready = 1'b1;
      end
`endif
      default: begin
        din_ready = 1'b0;
      end
    endcase
  end

  // Datapath: load on handshake, otherwise shift while in SHIFT. The counter
  // holds at 0 rather than wrapping when the frame is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
`ifdef PISO_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      frame_done <= last_bit;
      if (load) begin
        shreg <= din;
        cnt   <= CNT_LAST;
`ifdef PISO_PARITY_EN
        parity <= ^din;
`endif
      end else if (state == S_SHIFT) begin
        shreg <= shreg << 1;
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed and randomized stimulus for piso_serializer.
// A reference model predicts, per accepted word, the serial bits with their
// cycle numbers, the frame_done cycle and the word the downstream SIPO holds.
module tb_piso_serializer;

  localparam int   WIDTH      = 4;
  localparam logic IDLE_LEVEL = 1'b0;
`ifdef PISO_PARITY_EN
  localparam int   PB = 1;
`else
  localparam int   PB = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             SO;
  logic             so_valid;
  logic             frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int free_edge = 0;

  logic             exp_q[$];
  int               bit_cyc_q[$];
  int               fd_q[$];
  logic [WIDTH-1:0] word_q[$];
  logic [WIDTH-1:0] sipo;

  piso_serializer #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .SO         (SO),
    .so_valid   (so_valid),
    .frame_done (frame_done)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream SIPO model: shifts SO in every clock.
  always @(posedge clk) sipo <= {sipo[WIDTH-2:0], SO};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    bit_cyc_q.delete();
    fd_q.delete();
    word_q.delete();
    free_edge = 0;
  endtask

  // Reference model: a word is taken at edge c when the previous frame has
  // used up its WIDTH(+parity) bit slots; bits then occupy cycles c+1...
  always @(posedge clk) begin
    if (rst_n && din_valid && (cyc >= free_edge)) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        exp_q.push_back(din[i]);
        bit_cyc_q.push_back(cyc + WIDTH - i);
      end
      if (PB == 1) begin
        exp_q.push_back(^din);
        bit_cyc_q.push_back(cyc + WIDTH + 1);
      end
      fd_q.push_back(cyc + WIDTH + 1);
      word_q.push_back(din);
      free_edge = cyc + WIDTH + PB;
    end
  end

  // Monitor: compares every output against the model each cycle.
  always @(negedge clk) begin
    logic             exp_v;
    logic             exp_fd;
    logic             b;
    logic [WIDTH-1:0] w;
    if (rst_n) begin
      check("din_ready", din_ready, cyc >= free_edge);
      exp_v = (bit_cyc_q.size() > 0) ? (bit_cyc_q[0] == cyc) : 1'b0;
      check("so_valid", so_valid, exp_v);
      if (exp_v) begin
        b = exp_q.pop_front();
        void'(bit_cyc_q.pop_front());
        check("so_bit", SO, b);
      end else begin
        check("so_idle", SO, IDLE_LEVEL);
      end
      exp_fd = (fd_q.size() > 0) ? (fd_q[0] == cyc) : 1'b0;
      check("frame_done", frame_done, exp_fd);
      if (exp_fd) begin
        void'(fd_q.pop_front());
        w = word_q.pop_front();
        check("sipo_q", sipo, w);
      end
    end
  end

  // Driver: present a word and hold it until accepted (bounded wait).
  task automatic send(input logic [WIDTH-1:0] word);
    bit ok;
    ok = 1'b0;
    din       = word;
    din_valid = 1'b1;
    for (int n = 0; n < 4 * (WIDTH + 2); n++) begin
      @(posedge clk);
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    din_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout word=%0h got=not_accepted expected=accepted", word);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sipo      = '0;
    #1;
    check("rst_so", SO, IDLE_LEVEL);
    check("rst_so_valid", so_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_din_ready", din_ready, 1'b1);

    // Single frame.
    send(4'b1011);
    idle(WIDTH + 3);

    // Back-to-back frames, then boundary words.
    send(4'hA);
    send(4'h5);
    send(4'h0);
    send(4'hF);
    idle(WIDTH + 3);

    // Busy ignore: 4'hF offered during bits 2-3 of 4'hC.
    send(4'hC);
    idle(1);
    send(4'hF);
    idle(WIDTH + 3);

    // Async reset in the middle of a frame.
    send(4'h9);
    @(posedge clk);
    #3 rst_n = 1'b0;
    flush_model();
    #1;
    check("midrst_so", SO, IDLE_LEVEL);
    check("midrst_so_valid", so_valid, 1'b0);
    check("midrst_frame_done", frame_done, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("midrst_din_ready", din_ready, 1'b1);
    idle(WIDTH + 3);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      din_valid = ($urandom_range(0, 3) != 0);
      din       = WIDTH'($urandom);
    end
    din_valid = 1'b0;

    // Drain with a bound.
    for (int n = 0; n < 4 * (WIDTH + 2); n++) begin
      if (exp_q.size() == 0 && fd_q.size() == 0) break;
      @(posedge clk);
    end
    idle(2);
    check("drain_bits", exp_q.size(), 0);
    check("drain_frames", fd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
